// File: rtl/floo_credit_link_pkg.sv
// Shared helpers for credit-based FlooNoC links: sizing rules and the credit update encoding.
package floo_credit_link_pkg;

   // Credit counter update selected by {send, credit_return}
   typedef enum logic [1:0] {
      CrHold   = 2'b00,
      CrReturn = 2'b01,
      CrSend   = 2'b10,
      CrBoth   = 2'b11
   } credit_op_e;

   // Minimum credits for one flit per cycle across a link of the given latency
   function automatic int unsigned credit_min_depth(input int unsigned link_latency);
      return 2 * link_latency + 2;
   endfunction

   // Bits needed to hold 0..n, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/floo_credit_link_counter.sv
// Tx-side credit counter: spends a credit per sent flit, regains one per returned pulse.
module floo_credit_link_counter
   import floo_credit_link_pkg::*;
#(
   parameter int unsigned NumCredits = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic send,
   input  logic credit_return,
   output logic ready
);

   localparam int unsigned CntW = cnt_width(NumCredits);

   logic [CntW-1:0] credits_q, credits_d;
   logic            ready_q;
   credit_op_e      op;

   always_comb begin
      op        = credit_op_e'({send, credit_return});
      credits_d = credits_q;
      unique case (op)
         CrSend:   credits_d = credits_q - CntW'(1);
         CrReturn: credits_d = credits_q + CntW'(1);
         default:  ;
      endcase
   end

   // ready is kept as its own flop so it never depends on this cycle's inputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credits_q <= CntW'(NumCredits);
         ready_q   <= 1'b1;
      end else begin
         credits_q <= credits_d;
         ready_q   <= (credits_d != '0);
      end
   end

   assign ready = ready_q;

   credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(op == CrReturn && credits_q == CntW'(NumCredits)))
      else $error("floo_credit_link: credit count exceeds NumCredits");

   credit_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(op == CrSend && credits_q == '0))
      else $error("floo_credit_link: flit sent without a credit");

endmodule

// File: rtl/floo_credit_link.sv
// Credit-flow-controlled point-to-point link: pipelined data forward, pipelined credits back,
// receive FIFO sized to the credit count so no flit is ever dropped.
module floo_credit_link
   import floo_credit_link_pkg::*;
#(
   parameter type         flit_t      = logic,
   parameter int unsigned NumCredits  = 4,
   parameter int unsigned LinkLatency = 1
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  valid_i,
   output logic  ready_o,
   input  flit_t data_i,
   output logic  valid_o,
   input  logic  ready_i,
   output flit_t data_o
);

   localparam int unsigned CntW  = cnt_width(NumCredits);
   localparam int unsigned PtrW  = (NumCredits > 1) ? $clog2(NumCredits) : 1;
   localparam int unsigned Depth = (NumCredits > 0) ? NumCredits : 1;

   if (NumCredits == 0) begin : g_err_depth
      $error("floo_credit_link: NumCredits must be at least 1");
   end else if (NumCredits < credit_min_depth(LinkLatency)) begin : g_warn_depth
      $warning("floo_credit_link: NumCredits below 2*LinkLatency+2 throttles the link");
   end

   logic  send, pop, push;
   logic  fwd_valid, credit_ret;
   flit_t fwd_data;

   assign send = valid_i && ready_o;
   assign pop  = valid_o && ready_i;
   assign push = fwd_valid;

   floo_credit_link_counter #(
      .NumCredits (NumCredits)
   ) i_counter (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .send          (send),
      .credit_return (credit_ret),
      .ready         (ready_o)
   );

   // Forward {valid, flit} and backward credit pipes share the same stage count
   if (LinkLatency == 0) begin : g_direct
      assign fwd_valid  = send;
      assign fwd_data   = data_i;
      assign credit_ret = pop;
   end else begin : g_pipe
      for (genvar i = 0; i < LinkLatency; i++) begin : g_stage
         logic  v_in, c_in, v_q, c_q;
         flit_t d_in, d_q;

         if (i == 0) begin : g_head
            assign v_in = send;
            assign d_in = data_i;
            assign c_in = pop;
         end else begin : g_tail
            assign v_in = g_stage[i-1].v_q;
            assign d_in = g_stage[i-1].d_q;
            assign c_in = g_stage[i-1].c_q;
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               v_q <= 1'b0;
               d_q <= '0;
               c_q <= 1'b0;
            end else begin
               v_q <= v_in;
               d_q <= d_in;
               c_q <= c_in;
            end
         end
      end

      assign fwd_valid  = g_stage[LinkLatency-1].v_q;
      assign fwd_data   = g_stage[LinkLatency-1].d_q;
      assign credit_ret = g_stage[LinkLatency-1].c_q;
   end

   // Rx FIFO, non-fall-through: a flit written this cycle is visible next cycle
   flit_t           mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            not_empty_q;
   logic            full;

   assign full = (count_q == CntW'(NumCredits));

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         not_empty_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= fwd_data;
            wr_ptr_q        <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
         end
         count_q     <= count_d;
         not_empty_q <= (count_d != '0);
      end
   end

   assign valid_o = not_empty_q;
   assign data_o  = mem_q[rd_ptr_q];

   fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && full && !pop))
      else $error("floo_credit_link: rx FIFO written while full");

endmodule

// File: tb/tb_floo_credit_link.sv
// Randomized scoreboard bench for floo_credit_link (NumCredits=4, LinkLatency=1).
module tb_floo_credit_link;

   localparam int unsigned N = 4;
   localparam int unsigned L = 1;

   typedef logic [7:0] flit_t;
   typedef struct {
      flit_t data;
      int    arrival;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  valid_i = 1'b0;
   logic  ready_i = 1'b0;
   flit_t data_i = '0;
   logic  ready_o, valid_o;
   flit_t data_o;

   int    cyc = 0;
   int    vectors = 0;
   int    miscompares = 0;
   int    credits = int'(N);
   int    sent = 0;
   exp_t  exp_q[$];
   int    pop_q[$];

   floo_credit_link #(
      .flit_t      (flit_t),
      .NumCredits  (N),
      .LinkLatency (L)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // One cycle of stimulus; credit expectation follows from send/pop history alone
   task automatic drive(input logic v, input logic r, input flit_t d);
      @(negedge clk);
      while (pop_q.size() > 0 && pop_q[0] + int'(L) + 1 <= cyc) begin
         credits++;
         void'(pop_q.pop_front());
      end
      check("ready_o", 32'(ready_o), 32'(credits > 0));
      valid_i = v;
      ready_i = r;
      data_i  = d;
      if (v && ready_o) begin
         exp_q.push_back('{data: d, arrival: cyc + int'(L) + 1});
         credits--;
         sent++;
      end
   endtask

   task automatic mid_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      exp_q.delete();
      pop_q.delete();
      credits = int'(N);
      #1;
      check("rst_ready_o", 32'(ready_o), 32'd1);
      check("rst_valid_o", 32'(valid_o), 32'd0);
      check("rst_data_o", 32'(data_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: a flit is due once its arrival cycle is reached; pops are checked in order
   initial begin
      exp_t e;
      logic exp_v;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].arrival <= cyc);
            check("valid_o", 32'(valid_o), 32'(exp_v));
            if (valid_o && ready_i) begin
               pop_q.push_back(cyc);
               check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("data_o", 32'(data_o), 32'(e.data));
               end
            end
         end
      end
   end

   initial begin
      int s0;
      repeat (3) @(negedge clk);
      check("reset_ready_o", 32'(ready_o), 32'd1);
      check("reset_valid_o", 32'(valid_o), 32'd0);
      check("reset_data_o", 32'(data_o), 32'd0);
      rst_n = 1'b1;

      // single flit
      drive(1'b1, 1'b1, 8'hA5);
      repeat (5) drive(1'b0, 1'b1, 8'h00);

      // downstream stall: six flits offered, only four credits
      s0 = sent;
      repeat (6) drive(1'b1, 1'b0, 8'($urandom));
      check("stall_accepted", 32'(sent - s0), 32'd4);
      for (int k = 0; k < 30; k++) begin
         drive((sent - s0) < 6, 1'b1, 8'($urandom));
      end
      check("stall_all_sent", 32'(sent - s0), 32'd6);

      // full throughput
      s0 = sent;
      repeat (100) drive(1'b1, 1'b1, 8'($urandom));
      check("throughput_accepted", 32'(sent - s0), 32'd100);
      repeat (10) drive(1'b0, 1'b1, 8'h00);

      // random traffic and backpressure
      repeat (1500) drive(1'($urandom % 2), ($urandom % 4) != 0, 8'($urandom));
      mid_reset();
      repeat (1500) drive(($urandom % 4) != 0, ($urandom % 2) != 0, 8'($urandom));

      repeat (30) drive(1'b0, 1'b1, 8'h00);
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
